// File: rtl/alu_pkg.sv
// alu_pkg: ALUCtl encoding, FSM states and default control width shared by alu_mc
package alu_pkg;
  localparam int CTLW_DEF = 4;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_NOP = 4'b0011;
  localparam logic [3:0] ALU_GTZ = 4'b0100, ALU_SLT = 4'b0101, ALU_SUB = 4'b0110, ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000, ALU_DIVU = 4'b1001, ALU_MFHI = 4'b1010, ALU_MFLO = 4'b1011;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: ALU bus; master drives Op1/Op2/ALUCtl/Start, slave returns Res/ZF/Busy/Done/OF
interface alu_mc_if import alu_pkg::*; #(parameter int WIDTH = 32, parameter int CTLW = CTLW_DEF);
  logic [WIDTH-1:0] Op1, Op2, Res;
  logic [CTLW-1:0] ALUCtl;
  logic Start, ZF, Busy, Done, OF;
  modport master (output Op1, Op2, ALUCtl, Start, input Res, ZF, Busy, Done, OF);
  modport slave (input Op1, Op2, ALUCtl, Start, output Res, ZF, Busy, Done, OF);
endinterface

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one shift-add multiply (div=0) or restoring-divide (div=1) step on {acc,q} with operand m
module alu_mc_iter import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] sum, t, diff;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, m & {WIDTH{q[0]}}};
    t = {acc, q[WIDTH-1]};
    diff = t - {1'b0, m};
    acc_n = div ? (diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_n = div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: ALU with multi-cycle MULTU/DIVU into HI/LO; ports clk, rst_n (sync active-low), bus (alu_mc_if.slave); `define ALU_MC_OVF_EN enables OF
module alu_mc import alu_pkg::*; #(parameter int WIDTH = 32, parameter int CTLW = CTLW_DEF) (
  input logic clk,
  input logic rst_n,
  alu_mc_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, acc, q, m, acc_n, q_n, res;
  logic [3:0] op;
  logic busy, done;
  assign op = (bus.ALUCtl >> 4) != '0 ? 4'hf : bus.ALUCtl[3:0];
  always_comb begin
    res = '0;
    case (op)
      ALU_AND: res = bus.Op1 & bus.Op2;
      ALU_OR: res = bus.Op1 | bus.Op2;
      ALU_ADD: res = bus.Op1 + bus.Op2;
      ALU_SUB: res = bus.Op1 - bus.Op2;
      ALU_SLTU: res = WIDTH'(bus.Op1 < bus.Op2);
      ALU_SLT: res = WIDTH'($signed(bus.Op1) < $signed(bus.Op2));
      ALU_GTZ: res = WIDTH'(bus.Op1[WIDTH-1] || bus.Op1 == '0);
      ALU_MFHI: res = hi;
      ALU_MFLO: res = lo;
      ALU_NOP, ALU_MULTU, ALU_DIVU: res = '0;
      default: res = '0;
    endcase
  end
  assign bus.Res = res;
  assign bus.ZF = res == '0;
  assign bus.Busy = busy;
  assign bus.Done = done;
`ifdef ALU_MC_OVF_EN
  assign bus.OF = op == ALU_ADD ? (bus.Op1[WIDTH-1] == bus.Op2[WIDTH-1] && res[WIDTH-1] != bus.Op1[WIDTH-1]) :
                  op == ALU_SUB ? (bus.Op1[WIDTH-1] != bus.Op2[WIDTH-1] && res[WIDTH-1] != bus.Op1[WIDTH-1]) : 1'b0;
`else
  assign bus.OF = 1'b0;
`endif
  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (.div(state == S_DIV), .acc(acc), .q(q), .m(m), .acc_n(acc_n), .q_n(q_n));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {hi, lo, acc, q, m, cnt, busy, done} <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.Start && (op == ALU_MULTU || op == ALU_DIVU)) begin
          acc <= '0;
          q <= bus.Op1;
          m <= bus.Op2;
          cnt <= CW'(WIDTH);
          state <= op == ALU_MULTU ? S_MUL : S_DIV;
          busy <= 1'b1;
        end
        S_MUL, S_DIV: begin
          acc <= acc_n;
          q <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            hi <= acc_n;
            lo <= q_n;
          end
        end
        default: begin
          state <= S_IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plus randomized checks of alu_mc against a behavioural model
module tb_alu_mc;
  localparam int W = 32;
  logic clk = 0, rst_n = 0;
  int compared = 0, mismatched = 0;
  logic [W-1:0] mhi = '0, mlo = '0;
  alu_mc_if #(.WIDTH(W), .CTLW(4)) bus ();
  alu_mc #(.WIDTH(W), .CTLW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a, b, h, l);
    longint sa = $signed(a), sb = $signed(b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return W'(a + b);
      4'd6: return W'(a - b);
      4'd7: return W'(a < b);
      4'd5: return W'(sa < sb);
      4'd4: return sa > 0 ? 0 : 1;
      4'd10: return h;
      4'd11: return l;
      default: return 0;
    endcase
  endfunction
  function automatic logic model_of(input logic [3:0] op, input logic [W-1:0] a, b);
    longint sa = $signed(a), sb = $signed(b), r;
    r = op == 4'd2 ? sa + sb : sa - sb;
`ifdef ALU_MC_OVF_EN
    return (op == 4'd2 || op == 4'd6) && (r > 64'sd2147483647 || r < -64'sd2147483648);
`else
    return 1'b0 && r == 0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [3:0] op, input logic [W-1:0] a, b);
    bus.ALUCtl = op;
    bus.Op1 = a;
    bus.Op2 = b;
    #1;
  endtask
  task automatic comb(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] r;
    set(op, a, b);
    r = model_res(op, a, b, mhi, mlo);
    chk("res", bus.Res, r);
    chk("zf", bus.ZF, r == 0);
    chk("of", bus.OF, model_of(op, a, b));
  endtask
  task automatic chk_hl(input string tag);
    set(4'd10, $urandom, $urandom);
    chk({tag, "_hi"}, bus.Res, mhi);
    set(4'd11, $urandom, $urandom);
    chk({tag, "_lo"}, bus.Res, mlo);
  endtask
  task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [63:0] p;
    logic [W-1:0] eh, el;
    p = 64'(a) * 64'(b);
    eh = op == 4'd8 ? p[63:32] : (b == 0 ? a : a % b);
    el = op == 4'd8 ? p[31:0] : (b == 0 ? '1 : a / b);
    set(op, a, b);
    bus.Start = 1;
    tick;
    bus.Start = 0;
    for (int k = 1; k <= W; k++) begin
      if (k == 5) begin
        set(op ^ 4'd1, $urandom, $urandom);
        bus.Start = 1;
        chk("busy_res0", bus.Res, 0);
      end else begin
        set(k[0] ? 4'd10 : 4'd11, $urandom, $urandom);
        chk("busy_hold", bus.Res, k[0] ? mhi : mlo);
      end
      chk("busy", bus.Busy, 1);
      chk("busy_done", bus.Done, 0);
      tick;
      bus.Start = 0;
    end
    chk("done", bus.Done, 1);
    chk("done_busy", bus.Busy, 0);
    mhi = eh;
    mlo = el;
    chk_hl("result");
    set(op, ~a, ~b);
    bus.Start = 1;
    tick;
    bus.Start = 0;
    chk("after_done", bus.Done, 0);
    chk("after_busy", bus.Busy, 0);
    chk_hl("held");
  endtask
  initial begin
    bus.Start = 0;
    set(4'd3, 0, 0);
    tick;
    tick;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk_hl("rst");
    rst_n = 1;
    comb(4'd2, 32'hFFFFFFFF, 32'h1);
    chk("add_zf", bus.ZF, 1);
    comb(4'd6, 32'd5, 32'd7);
    comb(4'd5, 32'hFFFFFFFF, 32'h1);
    comb(4'd7, 32'hFFFFFFFF, 32'h1);
    comb(4'd4, 32'h80000000, 32'h0);
    comb(4'd4, 32'd3, 32'h0);
    comb(4'd4, 32'd0, 32'h0);
    comb(4'd3, 32'h1234, 32'h5678);
    comb(4'd12, 32'hFFFF, 32'hFFFF);
    comb(4'd2, 32'h7FFFFFFF, 32'h1);
    comb(4'd6, 32'h80000000, 32'h1);
    comb(4'd6, 32'h7FFFFFFF, 32'hFFFFFFFF);
    run_md(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_hi", mhi, 32'hFFFFFFFE);
    chk("mul_lo", mlo, 32'h1);
    run_md(4'd9, 32'd100, 32'd7);
    run_md(4'd9, 32'h1234, 32'h0);
    set(4'd8, $urandom, $urandom);
    bus.Start = 1;
    tick;
    bus.Start = 0;
    for (int k = 1; k < 10; k++) tick;
    rst_n = 0;
    tick;
    mhi = '0;
    mlo = '0;
    chk("midrst_busy", bus.Busy, 0);
    chk("midrst_done", bus.Done, 0);
    chk_hl("midrst");
    comb(4'd2, 32'd9, 32'd8);
    rst_n = 1;
    for (int k = 0; k < 40; k++) begin
      chk("norestart_done", bus.Done, 0);
      chk("norestart_busy", bus.Busy, 0);
      tick;
    end
    run_md(4'd8, 32'd3, 32'd4);
    for (int i = 0; i < 8; i++)
      run_md(4'($urandom_range(8, 9)), $urandom, i % 3 == 0 ? 32'($urandom_range(0, 20)) : $urandom);
    for (int i = 0; i < 100; i++)
      comb(4'($urandom_range(0, 15)), $urandom, i % 4 == 0 ? 32'($urandom_range(0, 3)) : $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised successor of the datapath ALU. Keeps the same single-cycle combinational ops on Res/ZF, so it drops into the existing execute stage unchanged.
- Adds unsigned multiply and divide. These run multi-cycle through a Start/Busy/Done handshake and write architectural HI/LO registers, which are read back via MFHI/MFLO.
- Sits in the execute stage. The controller stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand/result width (≥4, even).
- CTLW, 4, ALUCtl width (fixed encoding below; must be ≥4).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- Op1  in  WIDTH  operand A.
- Op2  in  WIDTH  operand B.
- ALUCtl  in  CTLW  operation select (from ALUControl).
- Start  in  1  launch MULTU/DIVU when ALUCtl selects one; ignored otherwise.
- Res  out  WIDTH  combinational result.
- ZF  out  1  high when Res == 0.
- Busy  out  1  multi-cycle op in progress.
- Done  out  1  one-cycle pulse; HI/LO hold the new result.
- OF  out  1  signed overflow (see Optional Feature).

Behaviour:
- ALUCtl encoding and Res (combinational, same cycle):
  - 0000 AND: Op1&Op2.
  - 0001 OR: Op1|Op2.
  - 0010 ADD: Op1+Op2, modulo 2^WIDTH.
  - 0110 SUB: Op1-Op2, modulo 2^WIDTH.
  - 0111 SLTU: 1 if unsigned Op1<Op2, else 0.
  - 0101 SLT: signed compare, otherwise as SLTU.
  - 0100 GTZ: 0 if signed Op1>0, else 1 (zero means take branch).
  - 0011 NOP: 0.
  - 1000 MULTU: 0 on Res; starts the multi-cycle multiply.
  - 1001 DIVU: 0 on Res; starts the multi-cycle divide.
  - 1010 MFHI: Res=HI.
  - 1011 MFLO: Res=LO.
  - Any other code: 0.
- ZF = (Res==0), combinational, for every op.
- FSM states IDLE, MUL, DIV, DONE. Iteration counter is $clog2(WIDTH+1) bits.
  - IDLE: on Start && ALUCtl∈{MULTU,DIVU}, latch Op1/Op2 into working registers, load counter=WIDTH, go to MUL or DIV.
  - MUL: unsigned shift-add, one bit per cycle; WIDTH cycles; then go to DONE.
  - DIV: restoring division, one quotient bit per cycle; WIDTH cycles; then go to DONE.
  - DONE: one cycle, then IDLE.
- Outputs per state:
  - Busy=1 in MUL and DIV only.
  - Done=1 in DONE only.
- Latency: Start sampled at edge N. Busy is high for cycles N+1..N+WIDTH. Done is high in cycle N+WIDTH+1. MFLO is valid from that cycle onward.
- HI/LO update:
  - Written only on entry to DONE; working registers are separate.
  - MFHI/MFLO during Busy return the previous result.
  - MULTU: {HI,LO} = full 2·WIDTH-bit product.
  - DIVU: LO=quotient, HI=remainder.
- Divide by zero: no trap. Full WIDTH cycles run; result is LO=all-ones, HI=Op1 dividend.
- Start while Busy or in DONE: ignored, no queueing.
- Start with a non-mul/div ALUCtl: ignored.
- Operands may change after the Start edge without affecting the result.
- rst_n low at any edge, including mid-operation:
  - State→IDLE; HI=LO=0; working registers and counter=0; Busy=0; Done=0.
  - The in-flight op is discarded.
- Res/ZF stay combinational during reset; reset affects only registered state.

Optional Feature:
- Macro ALU_MC_OVF_EN.
- Defined: OF=1 on signed overflow for ADD (operands have the same sign, result sign differs) and SUB (operands have different signs, result sign differs from Op1); 0 for all other ops. Combinational.
- Undefined: OF tied 0; no overflow logic synthesised.

Decomposition:
- Shared package alu_pkg:
  - ALUCtl encoding localparams (ALU_AND … ALU_MFLO).
  - FSM state enum/localparams.
  - CTLW default.
- Natural sub-module: alu_mc_iter. Holds the shared shift register/accumulator datapath for one MUL or DIV step, selected by mode. The top keeps the combinational ops, FSM, counter and HI/LO.

Test Plan:
- Combinational ops (WIDTH=32):
  - ADD 0xFFFFFFFF+1 → Res=0, ZF=1.
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU same operands → 0.
  - GTZ 0x80000000 → 1.
  - GTZ 3 → 0, ZF=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with Start at edge N:
  - Busy high N+1..N+32; Done pulse at N+33.
  - HI=0xFFFFFFFE, LO=0x00000001.
  - MFHI/MFLO during Busy return the prior values.
- DIVU 100/7 → LO=14, HI=2, Done after 33 cycles.
- DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
- Start re-asserted while Busy → ignored; first result is unchanged and only one Done pulse occurs.
- rst_n low at cycle N+10 of a MULTU:
  - Next edge: Busy=0, Done=0, HI=LO=0.
  - No Done pulse later.
  - A new MULTU 3×4 then gives LO=12, HI=0.
